// File: rtl/pa_steer_sequencer.sv
// rtl/pa_steer_sequencer.sv - phased-array write-port master: stop, duty, linear steering delays, run
module pa_steer_sequencer #(
  parameter int          NUM_SPK   = 37,
  parameter logic [5:0]  SPK_BASE  = 6'h10,
  parameter int          PHASE_CYC = 1
) (
  input  logic       clk10,
  input  logic       reset,
  input  logic       cmd_start,
  input  logic [5:0] cmd_step,
  input  logic [5:0] cmd_duty,
  input  logic       cmd_abort,
  output logic       sync,
  output logic       address,
  output logic [5:0] data,
  output logic       busy,
  output logic       done,
  output logic       aborted
);

  localparam int PW = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
  localparam logic [5:0] LAST_ITEM = 6'(NUM_SPK + 2);
  localparam logic [5:0] LAST_SPK  = 6'(NUM_SPK + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_SETUP, S_ADDR_STROBE, S_DATA_SETUP, S_DATA_STROBE, S_FINISH
  } state_t;

  state_t        state, state_nx;
  logic [PW-1:0] phase_cnt;
  logic [5:0]    item, acc, step_r, duty_r;
  logic          abort_pend, stop_mode, end_aborted;
  logic          in_write, phase_end, accept, abort_now, item_end, seq_end;
  logic [5:0]    cur_reg, cur_val;

  assign in_write  = (state != S_IDLE) && (state != S_FINISH);
  assign phase_end = (phase_cnt == PW'(PHASE_CYC - 1));
  assign accept    = (state == S_IDLE) && cmd_start && !cmd_abort;
  // Once the closing stop write is under way, further aborts change nothing.
  assign abort_now = (abort_pend || cmd_abort) && !stop_mode;
  assign item_end  = (state == S_DATA_STROBE) && phase_end;
  assign seq_end   = item_end && (stop_mode || (abort_now && item == 6'd0) ||
                                  (!abort_now && item == LAST_ITEM));

  always_comb begin
    cur_reg = SPK_BASE + item - 6'd2;
    cur_val = acc;
    if (stop_mode || item == 6'd0) begin
      cur_reg = 6'h01;
      cur_val = 6'd0;
    end else if (item == 6'd1) begin
      cur_reg = 6'h02;
      cur_val = duty_r;
    end else if (item == LAST_ITEM) begin
      cur_reg = 6'h01;
      cur_val = 6'd1;
    end
  end

  always_ff @(posedge clk10) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:        if (accept)    state_nx = S_ADDR_SETUP;
      S_ADDR_SETUP:  if (phase_end) state_nx = S_ADDR_STROBE;
      S_ADDR_STROBE: if (phase_end) state_nx = S_DATA_SETUP;
      S_DATA_SETUP:  if (phase_end) state_nx = S_DATA_STROBE;
      S_DATA_STROBE: if (phase_end) state_nx = seq_end ? S_FINISH : S_ADDR_SETUP;
      S_FINISH:      state_nx = S_IDLE;
      default:       state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk10) begin
    if (reset) begin
      phase_cnt   <= '0;
      item        <= '0;
      acc         <= '0;
      step_r      <= '0;
      duty_r      <= '0;
      abort_pend  <= 1'b0;
      stop_mode   <= 1'b0;
      end_aborted <= 1'b0;
    end else if (accept) begin
      phase_cnt   <= '0;
      item        <= '0;
      acc         <= '0;
      step_r      <= cmd_step;
      duty_r      <= cmd_duty;
      abort_pend  <= 1'b0;
      stop_mode   <= 1'b0;
      end_aborted <= 1'b0;
    end else if (in_write) begin
      phase_cnt <= phase_end ? '0 : phase_cnt + 1'b1;
      if (cmd_abort && !stop_mode) abort_pend <= 1'b1;
      if (item_end) begin
        if (!stop_mode && item >= 6'd2 && item <= LAST_SPK) acc <= acc + step_r;
        if (seq_end) begin
          end_aborted <= stop_mode || abort_now;
        end else if (abort_now) begin
          stop_mode <= 1'b1;
          item      <= 6'd0;
        end else begin
          item <= item + 6'd1;
        end
      end
    end
  end

  always_comb begin
    sync    = 1'b0;
    address = 1'b0;
    data    = 6'd0;
    busy    = 1'b0;
    done    = 1'b0;
    aborted = 1'b0;
    case (state)
      S_ADDR_SETUP:  begin busy = 1'b1; address = 1'b1; data = cur_reg; end
      S_ADDR_STROBE: begin busy = 1'b1; address = 1'b1; data = cur_reg; sync = 1'b1; end
      S_DATA_SETUP:  begin busy = 1'b1; data = cur_val; end
      S_DATA_STROBE: begin busy = 1'b1; data = cur_val; sync = 1'b1; end
      S_FINISH:      begin done = !end_aborted; aborted = end_aborted; end
      default:       ;
    endcase
  end

endmodule

// File: tb/tb_pa_steer_sequencer.sv
// tb/tb_pa_steer_sequencer.sv - three-configuration bench with a write-list reference model
module tb_pa_steer_sequencer;

  localparam int NS [3] = '{3, 6, 1};
  localparam int PC [3] = '{1, 1, 3};

  logic       clk10 = 1'b0;
  logic       reset;
  logic       st [3];
  logic       ab [3];
  logic [5:0] stp [3];
  logic [5:0] dty [3];
  logic       o_sync [3];
  logic       o_addr [3];
  logic [5:0] o_data [3];
  logic       o_busy [3];
  logic       o_done [3];
  logic       o_abt  [3];

  always #5 clk10 = ~clk10;

  pa_steer_sequencer #(.NUM_SPK(3), .SPK_BASE(6'h10), .PHASE_CYC(1)) u_a (
    .clk10(clk10), .reset(reset), .cmd_start(st[0]), .cmd_step(stp[0]), .cmd_duty(dty[0]),
    .cmd_abort(ab[0]), .sync(o_sync[0]), .address(o_addr[0]), .data(o_data[0]),
    .busy(o_busy[0]), .done(o_done[0]), .aborted(o_abt[0]));

  pa_steer_sequencer #(.NUM_SPK(6), .SPK_BASE(6'h10), .PHASE_CYC(1)) u_b (
    .clk10(clk10), .reset(reset), .cmd_start(st[1]), .cmd_step(stp[1]), .cmd_duty(dty[1]),
    .cmd_abort(ab[1]), .sync(o_sync[1]), .address(o_addr[1]), .data(o_data[1]),
    .busy(o_busy[1]), .done(o_done[1]), .aborted(o_abt[1]));

  pa_steer_sequencer #(.NUM_SPK(1), .SPK_BASE(6'h10), .PHASE_CYC(3)) u_c (
    .clk10(clk10), .reset(reset), .cmd_start(st[2]), .cmd_step(stp[2]), .cmd_duty(dty[2]),
    .cmd_abort(ab[2]), .sync(o_sync[2]), .address(o_addr[2]), .data(o_data[2]),
    .busy(o_busy[2]), .done(o_done[2]), .aborted(o_abt[2]));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got=%h expected=%h", nm, $time, got, exp);
    end
  endtask

  // The k-th write of a run: stop, duty, speakers k*step mod 64, run.
  function automatic logic [11:0] exp_write(input int nspk, input int itm, input bit stop,
                                            input logic [5:0] step, input logic [5:0] duty);
    int k;
    if (stop || itm == 0) return {6'h01, 6'h00};
    if (itm == 1) return {6'h02, duty};
    if (itm == nspk + 2) return {6'h01, 6'h01};
    k = itm - 2;
    return {6'(16 + k), 6'((k * int'(step)) % 64)};
  endfunction

  int         m_item [3];
  int         m_pos  [3];
  int         m_fin  [3];
  bit         m_busy [3];
  bit         m_pend [3];
  bit         m_stop [3];
  logic [5:0] m_step [3];
  logic [5:0] m_duty [3];

  task automatic model_end(input int i, input int f);
    m_busy[i] = 1'b0;
    m_fin[i]  = f;
  endtask

  always @(posedge clk10) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        m_busy[i] = 1'b0; m_fin[i] = 0; m_item[i] = 0; m_pos[i] = 0;
        m_pend[i] = 1'b0; m_stop[i] = 1'b0;
      end else if (m_fin[i] != 0) begin
        m_fin[i] = 0;
      end else if (!m_busy[i]) begin
        if (st[i] && !ab[i]) begin
          m_busy[i] = 1'b1; m_item[i] = 0; m_pos[i] = 0; m_pend[i] = 1'b0; m_stop[i] = 1'b0;
          m_step[i] = stp[i]; m_duty[i] = dty[i];
        end
      end else begin
        bit abt;
        if (ab[i] && !m_stop[i]) m_pend[i] = 1'b1;
        abt = m_pend[i] && !m_stop[i];
        m_pos[i]++;
        if (m_pos[i] == 4 * PC[i]) begin
          m_pos[i] = 0;
          if (m_stop[i]) model_end(i, 2);
          else if (abt) begin
            if (m_item[i] == 0) model_end(i, 2);
            else m_stop[i] = 1'b1;
          end else if (m_item[i] == NS[i] + 2) model_end(i, 1);
          else m_item[i]++;
        end
      end
    end
  end

  function automatic logic [10:0] exp_out(input int i);
    logic [11:0] w;
    int ph;
    if (!m_busy[i]) return {9'd0, m_fin[i] == 1, m_fin[i] == 2};
    w  = exp_write(NS[i], m_item[i], m_stop[i], m_step[i], m_duty[i]);
    ph = m_pos[i] / PC[i];
    return {ph[0], ph < 2, (ph < 2) ? w[11:6] : w[5:0], 1'b1, 2'b00};
  endfunction

  logic [11:0] wlog_a[$];
  logic [11:0] wlog_b[$];
  logic [5:0]  creg [3];
  logic        ps [3];
  int          busy_cnt [3];
  int          done_cnt [3];
  int          abt_cnt  [3];
  int          run_c, nrun_c, bad_run_c;

  task automatic clear_stats();
    wlog_a.delete();
    wlog_b.delete();
    for (int i = 0; i < 3; i++) begin busy_cnt[i] = 0; done_cnt[i] = 0; abt_cnt[i] = 0; end
    run_c = 0; nrun_c = 0; bad_run_c = 0;
  endtask

  always @(negedge clk10) begin
    for (int i = 0; i < 3; i++) begin
      check($sformatf("cycle_out_%0d", i),
            {21'd0, o_sync[i], o_addr[i], o_data[i], o_busy[i], o_done[i], o_abt[i]},
            {21'd0, exp_out(i)});
      busy_cnt[i] += int'(o_busy[i]);
      done_cnt[i] += int'(o_done[i]);
      abt_cnt[i]  += int'(o_abt[i]);
      if (o_sync[i] && !ps[i]) begin
        if (o_addr[i]) creg[i] = o_data[i];
        else if (i == 0) wlog_a.push_back({creg[i], o_data[i]});
        else if (i == 1) wlog_b.push_back({creg[i], o_data[i]});
      end
    end
    if (o_sync[2]) run_c++;
    else begin
      if (ps[2]) begin nrun_c++; if (run_c != 3) bad_run_c++; end
      run_c = 0;
    end
    for (int i = 0; i < 3; i++) ps[i] = o_sync[i];
  end

  task automatic check_log_a(input string nm, input logic [11:0] e [$]);
    check({nm, "_count"}, wlog_a.size(), e.size());
    for (int k = 0; k < e.size() && k < wlog_a.size(); k++)
      check($sformatf("%s_w%0d", nm, k), {20'd0, wlog_a[k]}, {20'd0, e[k]});
  endtask

  task automatic start_a(input logic [5:0] step, input logic [5:0] duty);
    st[0] = 1'b1; stp[0] = step; dty[0] = duty;
    @(negedge clk10);
    st[0] = 1'b0;
  endtask

  logic [11:0] exp_a[$];
  logic [11:0] exp_ab[$];
  logic [5:0]  duty_b;

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      st[i] = 1'b0; ab[i] = 1'b0; stp[i] = 6'd0; dty[i] = 6'd0; ps[i] = 1'b0; creg[i] = 6'd0;
    end
    clear_stats();
    exp_a  = '{{6'h01, 6'h00}, {6'h02, 6'h08}, {6'h10, 6'h00}, {6'h11, 6'h01},
               {6'h12, 6'h02}, {6'h01, 6'h01}};
    exp_ab = '{{6'h01, 6'h00}, {6'h02, 6'h08}, {6'h10, 6'h00}, {6'h11, 6'h01},
               {6'h01, 6'h00}};
    check("model_pin_spk2", {20'd0, exp_write(3, 4, 1'b0, 6'd1, 6'd8)}, {20'd0, 6'h12, 6'h02});
    check("model_pin_wrap", {20'd0, exp_write(6, 7, 1'b0, 6'd15, 6'd0)}, {20'd0, 6'h15, 6'h0b});
    repeat (3) @(negedge clk10);
    check("reset_outputs", {21'd0, o_sync[0], o_addr[0], o_data[0], o_busy[0], o_done[0], o_abt[0]}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk10);

    // Basic runs on all three configurations at once.
    duty_b = 6'($urandom);
    st[0] = 1'b1; stp[0] = 6'd1;  dty[0] = 6'd8;
    st[1] = 1'b1; stp[1] = 6'd15; dty[1] = duty_b;
    st[2] = 1'b1; stp[2] = 6'($urandom); dty[2] = 6'($urandom);
    @(negedge clk10);
    for (int i = 0; i < 3; i++) st[i] = 1'b0;
    repeat (60) @(negedge clk10);
    check_log_a("seq3", exp_a);
    check("seq3_busy", busy_cnt[0], 24);
    check("seq3_done", done_cnt[0], 1);
    check("seq3_abt", abt_cnt[0], 0);
    check("wrap_count", wlog_b.size(), 9);
    for (int k = 0; k < 6 && k + 2 < wlog_b.size(); k++)
      check($sformatf("wrap_spk%0d", k), {20'd0, wlog_b[k + 2]},
            {20'd0, 6'(6'h10 + k), 6'((15 * k) % 64)});
    if (wlog_b.size() == 9) begin
      check("wrap_duty", {20'd0, wlog_b[1]}, {20'd0, 6'h02, duty_b});
      check("wrap_final", {20'd0, wlog_b[8]}, {20'd0, 6'h01, 6'h01});
    end
    check("phase3_busy", busy_cnt[2], 48);
    check("phase3_runs", nrun_c, 8);
    check("phase3_badruns", bad_run_c, 0);
    check("phase3_done", done_cnt[2], 1);

    // Abort sampled at the end of speaker 1 DATA_SETUP (cycle 14 after accept).
    clear_stats();
    start_a(6'd1, 6'd8);
    repeat (14) @(negedge clk10);
    ab[0] = 1'b1;
    @(negedge clk10);
    ab[0] = 1'b0;
    repeat (20) @(negedge clk10);
    check_log_a("abort", exp_ab);
    check("abort_pulse", abt_cnt[0], 1);
    check("abort_nodone", done_cnt[0], 0);
    check("abort_busy", busy_cnt[0], 20);

    // Start while busy is ignored; start together with abort when idle starts nothing.
    clear_stats();
    start_a(6'd1, 6'd8);
    repeat (5) @(negedge clk10);
    start_a(6'd5, 6'd33);
    repeat (25) @(negedge clk10);
    check_log_a("start_busy", exp_a);
    check("start_busy_done", done_cnt[0], 1);
    st[0] = 1'b1; ab[0] = 1'b1;
    @(negedge clk10);
    st[0] = 1'b0; ab[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("start_abort_idle%0d", k), o_busy[0], 1'b0);
      @(negedge clk10);
    end

    // Reset during item 0 ADDR_STROBE.
    clear_stats();
    start_a(6'd3, 6'd4);
    @(negedge clk10);
    check("pre_reset_strobe", {o_sync[0], o_addr[0]}, 2'b11);
    reset = 1'b1;
    @(negedge clk10);
    check("mid_reset_out", {23'd0, o_sync[0], o_addr[0], o_data[0], o_busy[0]}, 32'd0);
    reset = 1'b0;
    repeat (10) @(negedge clk10);
    check("mid_reset_nodone", done_cnt[0], 0);

    // Randomized traffic on all three instances.
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 3; i++) begin
        st[i]  = ($urandom % 8) == 0;
        ab[i]  = ($urandom % 40) == 0;
        stp[i] = 6'($urandom);
        dty[i] = 6'($urandom);
      end
      reset = ($urandom % 1500) == 0;
      @(negedge clk10);
    end
    for (int i = 0; i < 3; i++) begin st[i] = 1'b0; ab[i] = 1'b0; end
    reset = 1'b0;
    repeat (60) @(negedge clk10);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
